// File: rtl/dcp_io_arb.sv
// Shared TX/RX unit arbiter for four command processors.
// Each channel is an independent round-robin arbiter with a grant watchdog.

module dcp_io_arb_chan #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req_i,
    input  logic [3:0] type_i,
    input  logic       ack_i,
    output logic       req_o,
    output logic       type_o,
    output logic [3:0] ack_o,
    output logic [1:0] gnt_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rrPtr_q, rrPtr_d;
    logic [15:0] wdog_q, wdog_d;
    logic        errTo_q, errTo_d;
    logic [1:0]  pick;

    // Descending scan so the requester closest to rrPtr_q wins.
    always_comb begin
        pick = rrPtr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[rrPtr_q + 2'(i)]) pick = rrPtr_q + 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        wdog_d  = 16'd0;
        errTo_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    owner_d = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wdog_d = wdog_q + 16'd1;
                // Ack has priority over both abandon and watchdog expiry.
                if (ack_i || !req_i[owner_q]) begin
                    state_d = ST_RELEASE;
                    rrPtr_d = owner_q + 2'd1;
                end else if (wdog_q == TIMEOUT - 16'd2) begin
                    state_d = ST_RELEASE;
                    rrPtr_d = owner_q + 2'd1;
                    errTo_d = 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            rrPtr_q <= 2'd0;
            wdog_q  <= 16'd0;
            errTo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
            wdog_q  <= wdog_d;
            errTo_q <= errTo_d;
        end
    end

    assign busy_o = (state_q == ST_GRANT);
    assign req_o  = busy_o & req_i[owner_q];
    assign type_o = busy_o & type_i[owner_q];
    assign ack_o  = (busy_o & ack_i) ? (4'b0001 << owner_q) : 4'b0000;
    assign gnt_o  = owner_q;
    assign err_o  = errTo_q;

endmodule

module dcp_io_arb #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [3:0]   req_tx_i,
    input  logic [3:0]   type_tx_i,
    input  logic [127:0] dout_i,
    output logic [3:0]   ack_tx_o,
    input  logic [3:0]   req_rx_i,
    input  logic [3:0]   type_rx_i,
    output logic [3:0]   ack_rx_o,
    output logic         req_tx,
    output logic         type_tx,
    output logic [31:0]  dout,
    input  logic         ack_tx,
    output logic         req_rx,
    output logic         type_rx,
    input  logic         ack_rx,
    output logic [1:0]   gnt_tx,
    output logic [1:0]   gnt_rx,
    output logic         busy_tx,
    output logic         busy_rx,
    output logic [1:0]   err_timeout
);

    logic errTx, errRx;

    dcp_io_arb_chan #(.TIMEOUT(TIMEOUT)) u_tx (
        .clk(clk), .rstn(rstn), .req_i(req_tx_i), .type_i(type_tx_i), .ack_i(ack_tx),
        .req_o(req_tx), .type_o(type_tx), .ack_o(ack_tx_o), .gnt_o(gnt_tx),
        .busy_o(busy_tx), .err_o(errTx)
    );

    dcp_io_arb_chan #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk(clk), .rstn(rstn), .req_i(req_rx_i), .type_i(type_rx_i), .ack_i(ack_rx),
        .req_o(req_rx), .type_o(type_rx), .ack_o(ack_rx_o), .gnt_o(gnt_rx),
        .busy_o(busy_rx), .err_o(errRx)
    );

    assign dout        = busy_tx ? dout_i[{gnt_tx, 5'd0} +: 32] : 32'd0;
    assign err_timeout = {errRx, errTx};

endmodule

// File: tb/tb_dcp_io_arb.sv
// Scoreboard bench for dcp_io_arb: stimulus queues expected grants, a monitor
// pops and checks them as each channel enters GRANT.

module tb_dcp_io_arb;

   logic         clk;
   logic         rstn;
   logic [3:0]   req_tx_i, type_tx_i, req_rx_i, type_rx_i;
   logic [127:0] dout_i;
   logic [3:0]   ack_tx_o, ack_rx_o;
   logic         req_tx, type_tx, req_rx, type_rx;
   logic [31:0]  dout;
   logic         ack_tx, ack_rx;
   logic [1:0]   gnt_tx, gnt_rx, err_timeout;
   logic         busy_tx, busy_rx;

   typedef struct {
      logic [1:0]  owner;
      logic [31:0] data;
      logic        typ;
   } exp_t;

   exp_t expTx[$];
   exp_t expRx[$];
   exp_t curTx, curRx;
   int   nCompared = 0;
   int   nMismatch = 0;
   logic busyTxPrev = 1'b0;
   logic busyRxPrev = 1'b0;

   dcp_io_arb #(.TIMEOUT(16'd16)) dut (
      .clk(clk), .rstn(rstn),
      .req_tx_i(req_tx_i), .type_tx_i(type_tx_i), .dout_i(dout_i), .ack_tx_o(ack_tx_o),
      .req_rx_i(req_rx_i), .type_rx_i(type_rx_i), .ack_rx_o(ack_rx_o),
      .req_tx(req_tx), .type_tx(type_tx), .dout(dout), .ack_tx(ack_tx),
      .req_rx(req_rx), .type_rx(type_rx), .ack_rx(ack_rx),
      .gnt_tx(gnt_tx), .gnt_rx(gnt_rx), .busy_tx(busy_tx), .busy_rx(busy_rx),
      .err_timeout(err_timeout)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something upstream of the bounded waits goes wrong
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish by 200000");
      $fatal(1, "[TB] simulation did not terminate");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitBusy(input bit rx, output int cycles);
      cycles = 0;
      while (cycles < 50) begin
         @(negedge clk);
         cycles++;
         if ((rx ? busy_rx : busy_tx) === 1'b1) return;
      end
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL wait_busy: got no grant after %0d cycles, expected grant", cycles);
   endtask

   // One TX transaction: request with mask, expect owner, ack after ackDelay cycles
   task automatic applyStimulus(input logic [3:0] mask, input logic [1:0] owner,
                                input int ackDelay, input bit hold, output int latency);
      expTx.push_back('{owner, dout_i[32*owner +: 32], type_tx_i[owner]});
      req_tx_i = mask;
      waitBusy(1'b0, latency);
      repeat (ackDelay) tick();
      ack_tx = 1'b1;
      tick();
      ack_tx = 1'b0;
      if (!hold) req_tx_i = 4'b0000;
      @(negedge clk);
      checkOutput("release_busy", 32'(busy_tx), 32'd0);
      checkOutput("release_req", 32'(req_tx), 32'd0);
      checkOutput("release_ack", 32'(ack_tx_o), 32'd0);
      tick();
      checkOutput("idle_busy", 32'(busy_tx), 32'd0);
   endtask

   // Monitor: pop expected grant on each rising busy, check ack routing on each ack
   always @(negedge clk) begin
      if (busy_tx && !busyTxPrev) begin
         if (expTx.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("[TB] FAIL tx_grant: got unexpected grant to %0d, expected none", gnt_tx);
         end else begin
            curTx = expTx.pop_front();
            checkOutput("tx_gnt", 32'(gnt_tx), 32'(curTx.owner));
            checkOutput("tx_dout", dout, curTx.data);
            checkOutput("tx_type", 32'(type_tx), 32'(curTx.typ));
            checkOutput("tx_req", 32'(req_tx), 32'd1);
         end
      end
      if (ack_tx)
         checkOutput("tx_ack_route", 32'(ack_tx_o),
                     busy_tx ? 32'(4'b0001 << curTx.owner) : 32'd0);
      busyTxPrev = busy_tx;

      if (busy_rx && !busyRxPrev) begin
         if (expRx.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("[TB] FAIL rx_grant: got unexpected grant to %0d, expected none", gnt_rx);
         end else begin
            curRx = expRx.pop_front();
            checkOutput("rx_gnt", 32'(gnt_rx), 32'(curRx.owner));
            checkOutput("rx_type", 32'(type_rx), 32'(curRx.typ));
            checkOutput("rx_req", 32'(req_rx), 32'd1);
         end
      end
      if (ack_rx)
         checkOutput("rx_ack_route", 32'(ack_rx_o),
                     busy_rx ? 32'(4'b0001 << curRx.owner) : 32'd0);
      busyRxPrev = busy_rx;
   end

   // Directed stimulus sequence
   initial begin
      int lat;
      int hi;
      int errs;
      logic [3:0] ackSeen;

      rstn      = 1'b0;
      req_tx_i  = 4'b0000;
      type_tx_i = 4'b1001;
      req_rx_i  = 4'b0000;
      type_rx_i = 4'b0100;
      ack_tx    = 1'b0;
      ack_rx    = 1'b0;
      dout_i    = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'h00000046};

      repeat (2) @(negedge clk);
      checkOutput("rst_req_tx", 32'(req_tx), 32'd0);
      checkOutput("rst_busy", 32'({busy_tx, busy_rx}), 32'd0);
      checkOutput("rst_gnt", 32'({gnt_tx, gnt_rx}), 32'd0);
      checkOutput("rst_err", 32'(err_timeout), 32'd0);
      checkOutput("rst_dout", dout, 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      $display("[TB] single TX transaction");
      applyStimulus(4'b0001, 2'd0, 5, 1'b0, lat);
      checkOutput("grant_latency", 32'(lat), 32'd2);

      $display("[TB] round robin with all four requesting");
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      for (int k = 0; k < 5; k++)
         applyStimulus(4'b1111, 2'(k), 1, (k < 4), lat);

      $display("[TB] concurrent TX and RX");
      expRx.push_back('{2'd2, 32'd0, 1'b1});
      expTx.push_back('{2'd1, 32'hBBBB0001, 1'b0});
      req_rx_i = 4'b0100;
      req_tx_i = 4'b0010;
      waitBusy(1'b0, lat);
      checkOutput("concurrent_busy_rx", 32'(busy_rx), 32'd1);
      checkOutput("concurrent_lat", 32'(lat), 32'd2);
      tick();
      ack_rx = 1'b1;
      @(negedge clk);
      checkOutput("tx_ack_quiet", 32'(ack_tx_o), 32'd0);
      tick();
      ack_rx   = 1'b0;
      req_rx_i = 4'b0000;
      ack_tx   = 1'b1;
      tick();
      ack_tx   = 1'b0;
      req_tx_i = 4'b0000;
      repeat (2) tick();

      $display("[TB] watchdog timeout on requester 3");
      expTx.push_back('{2'd3, 32'hDDDD0003, 1'b1});
      req_tx_i = 4'b1000;
      hi = 0;
      errs = 0;
      ackSeen = 4'b0000;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_tx) hi++;
         if (err_timeout == 2'b01) begin
            errs++;
            req_tx_i = 4'b0000;
         end else if (err_timeout != 2'b00) begin
            errs += 100;
         end
         ackSeen |= ack_tx_o;
      end
      checkOutput("timeout_req_cycles", 32'(hi), 32'd15);
      checkOutput("timeout_err_pulses", 32'(errs), 32'd1);
      checkOutput("timeout_no_ack", 32'(ackSeen), 32'd0);
      tick();
      applyStimulus(4'b1001, 2'd0, 2, 1'b0, lat);

      $display("[TB] abandon by requester 0");
      applyStimulus(4'b0100, 2'd2, 1, 1'b0, lat);
      expTx.push_back('{2'd0, 32'h00000046, 1'b1});
      req_tx_i = 4'b0001;
      waitBusy(1'b0, lat);
      tick();
      req_tx_i = 4'b0000;
      @(negedge clk);
      checkOutput("abandon_req_low", 32'(req_tx), 32'd0);
      tick();
      checkOutput("abandon_release", 32'(busy_tx), 32'd0);
      tick();
      applyStimulus(4'b1111, 2'd1, 0, 1'b0, lat);

      $display("[TB] reset during GRANT");
      expTx.push_back('{2'd2, 32'hCCCC0002, 1'b0});
      req_tx_i = 4'b0100;
      waitBusy(1'b0, lat);
      rstn = 1'b0;
      #1;
      checkOutput("reset_req_tx", 32'(req_tx), 32'd0);
      checkOutput("reset_gnt_tx", 32'(gnt_tx), 32'd0);
      checkOutput("reset_busy_tx", 32'(busy_tx), 32'd0);
      ack_tx = 1'b1;
      #1;
      checkOutput("reset_ack_blocked", 32'(ack_tx_o), 32'd0);
      ack_tx   = 1'b0;
      req_tx_i = 4'b0000;
      tick();
      rstn = 1'b1;
      tick();

      $display("[TB] stray ack in IDLE");
      ack_tx = 1'b1;
      @(negedge clk);
      checkOutput("stray_ack_o", 32'(ack_tx_o), 32'd0);
      tick();
      ack_tx = 1'b0;
      tick();
      checkOutput("stray_busy", 32'(busy_tx), 32'd0);
      applyStimulus(4'b1111, 2'd0, 1, 1'b0, lat);

      repeat (3) tick();
      checkOutput("tx_queue_empty", 32'(expTx.size()), 32'd0);
      checkOutput("rx_queue_empty", 32'(expRx.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/dcp_io_arb.md
DCP_IO_ARB -- requirements
Module: dcp_io_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: max cycles a grant may wait for downstream ack.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_tx_i / type_tx_i  input  4 / 4  per-requester TX request and TX type; requesters 0..3 are command processors.
REQ-005 SHALL have port dout_i  input  128  per-requester TX data; requester k on bits [32k+31:32k].
REQ-006 SHALL have port ack_tx_o  output  4  per-requester TX acknowledge.
REQ-007 SHALL have ports req_rx_i / type_rx_i  input  4 / 4  per-requester RX request and RX type.
REQ-008 SHALL have port ack_rx_o  output  4  per-requester RX acknowledge.
REQ-009 SHALL have ports req_tx / type_tx / dout  output  1 / 1 / 32  to the shared TX unit.
REQ-010 SHALL have port ack_tx  input  1  TX unit acknowledge, one-cycle pulse.
REQ-011 SHALL have ports req_rx / type_rx  output  1 / 1  to the shared RX unit.
REQ-012 SHALL have port ack_rx  input  1  RX unit acknowledge, one-cycle pulse; din_rx/flag_rx are broadcast outside this block.
REQ-013 SHALL have ports gnt_tx / gnt_rx  output  2 / 2  index of current owner, each channel.
REQ-014 SHALL have ports busy_tx / busy_rx  output  1 / 1  channel in GRANT state.
REQ-015 SHALL have port err_timeout  output  2  one-cycle pulse per channel on watchdog expiry; bit0 TX, bit1 RX.

Function
REQ-016 SHALL contain two independent, identical arbiters (TX, RX); rules below apply to each.
REQ-017 SHALL implement states IDLE, GRANT, RELEASE per channel.
REQ-018 IDLE: any req bit set -> register owner = first requester at or after rr_ptr, cyclic order; next cycle GRANT; no requests -> stay IDLE.
REQ-019 GRANT: downstream req = req_i[owner], type = type_i[owner], data (TX only) = dout_i[owner]; combinational mux from registered owner.
REQ-020 Outside GRANT: downstream req = 0, type = 0, dout = 0.
REQ-021 ack_o[owner] SHALL equal downstream ack during GRANT only; all other ack_o bits 0; ack outside GRANT discarded.
REQ-022 GRANT + downstream ack = 1 -> RELEASE; rr_ptr <= owner+1 mod 4.
REQ-023 GRANT + req_i[owner] = 0 (abandon), no ack -> RELEASE; rr_ptr <= owner+1 mod 4.
REQ-024 GRANT: watchdog counter increments each cycle; reaching TIMEOUT-1 without ack -> RELEASE, err_timeout bit pulses 1 cycle, no ack_o issued, rr_ptr <= owner+1.
REQ-025 Ack and watchdog expiry same cycle: ack wins, no error pulse.
REQ-026 RELEASE: exactly one cycle, downstream req 0, watchdog cleared; then IDLE.
REQ-027 Grant latency: request seen in IDLE cycle n -> downstream req high cycle n+1; back-to-back transactions separated by RELEASE + IDLE (min 2 idle cycles).
REQ-028 Requests other than owner's SHALL be ignored during GRANT/RELEASE; never preempt.
REQ-029 gnt_* holds last owner in IDLE/RELEASE; busy_* = 1 only in GRANT.

Reset
REQ-030 rstn low SHALL asynchronously force both channels to IDLE, rr_ptr = 0, owner = 0, watchdog = 0, err_timeout = 0; all outputs 0 during reset.
REQ-031 Reset asserted mid-GRANT SHALL drop downstream req immediately; no ack forwarded.

Verification
REQ-032 Single TX: req_tx_i=0001, dout_i[31:0]=32'h46, TX acks after 5 cycles -> req_tx=1, dout=32'h46 from cycle 1; ack_tx_o=0001 one cycle; gnt_tx=0; then RELEASE, IDLE.
REQ-033 Round-robin: req_tx_i=1111 held, every transaction acked -> owner order 0,1,2,3,0; each dout matches owner's slice.
REQ-034 Concurrent channels: requester 2 RX, requester 1 TX same cycle -> both granted next cycle, independent acks routed to ack_rx_o=0100, ack_tx_o=0010.
REQ-035 Timeout: TIMEOUT=16, requester 3 requests, no ack -> req_tx high 15 cycles, err_timeout=01 one cycle, ack_tx_o stays 0, next grant starts at requester 0.
REQ-036 Abandon/reset: requester 0 drops req in GRANT -> RELEASE next cycle, rr_ptr=1; separately, rstn low in GRANT -> req_tx=0 same cycle, gnt_tx=0, busy_tx=0.
REQ-037 Stray ack: ack_tx pulse while IDLE -> ack_tx_o=0000, state unchanged.
